// File: rtl/scaler_pkg.sv
// Shared sizing for the scaler line-buffer path.
// Pixel format, column address width and ring depth.
package scaler_pkg;

    localparam int SC_DATA_WIDTH    = 24;
    localparam int SC_ADDRESS_WIDTH = 11;
    localparam int SC_LINE_NUM      = 4;
    localparam int SC_PTR_WIDTH     = 2;
    localparam int SC_CNT_WIDTH     = SC_PTR_WIDTH + 1;

    typedef logic [SC_PTR_WIDTH-1:0] sc_ptr_t;
    typedef logic [SC_CNT_WIDTH-1:0] sc_cnt_t;

endpackage

// File: rtl/line_ring_fifo_line_ram.sv
// One line of pixel storage: simple dual-port RAM with a registered read port.
// Only the read register is reset; array contents survive reset and frame clear.
module line_ram #(
    parameter int DATA_WIDTH    = 24,
    parameter int ADDRESS_WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wrEn,
    input  logic [ADDRESS_WIDTH-1:0] i_wrAddr,
    input  logic [DATA_WIDTH-1:0]    i_wrData,
    input  logic                     i_rdEn,
    input  logic [ADDRESS_WIDTH-1:0] i_rdAddr,
    output logic [DATA_WIDTH-1:0]    o_rdData
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Read register holds its value while i_rdEn is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rdEn) begin
            r_rd_data <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rd_data;

endmodule

// File: rtl/line_ring_fifo.sv
// Line-buffer ring between decimation and interpolation: the writer commits whole
// lines, the reader sees a vertically adjacent top/bottom pair per column.
module line_ring_fifo
    import scaler_pkg::*;
#(
    parameter int DATA_WIDTH    = SC_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = SC_ADDRESS_WIDTH,
    parameter int LINE_NUM      = SC_LINE_NUM,
    parameter int PTR_WIDTH     = SC_PTR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_frmClr,
    input  logic                     i_wrEn,
    input  logic [ADDRESS_WIDTH-1:0] i_wrAddr,
    input  logic [DATA_WIDTH-1:0]    i_wrData,
    input  logic                     i_wrJmp,
    output logic [PTR_WIDTH:0]       o_fifoNum,
    input  logic                     i_rdEn,
    input  logic [ADDRESS_WIDTH-1:0] i_rdAddr,
    input  logic                     i_rdJmp,
    output logic                     o_rdReady,
    output logic [DATA_WIDTH-1:0]    o_dataTop,
    output logic [DATA_WIDTH-1:0]    o_dataBot,
    output logic                     o_dataVld,
    output logic                     o_ovfErr,
    output logic                     o_udfErr
);

    localparam int                   CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(LINE_NUM);

    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_fifo_num;
    logic                  r_rd_ready;
    logic                  r_data_vld;
    logic                  r_ovf_err;
    logic                  r_udf_err;
    logic [PTR_WIDTH-1:0]  r_sel_top;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic [PTR_WIDTH-1:0]  w_sel_bot;
    logic [DATA_WIDTH-1:0] w_line_data [LINE_NUM];

    // Acceptance uses the pre-edge count, so wrJmp+rdJmp when full retires only.
    assign w_full   = (r_fifo_num == FULL_CNT);
    assign w_empty  = (r_fifo_num == '0);
    assign w_wr_acc = i_wrJmp && !w_full;
    assign w_rd_acc = i_rdJmp && !w_empty;

    always_comb begin
        w_cnt_nxt = r_fifo_num;
        if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_fifo_num + CNT_WIDTH'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_cnt_nxt = r_fifo_num - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_num <= '0;
            r_rd_ready <= 1'b0;
            r_data_vld <= 1'b0;
        end else if (i_frmClr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_num <= '0;
            r_rd_ready <= 1'b0;
            r_data_vld <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
            r_fifo_num <= w_cnt_nxt;
            r_rd_ready <= (w_cnt_nxt >= CNT_WIDTH'(2));
            r_data_vld <= i_rdEn;
        end
    end

    // Error flags are sticky across frame clears; only rst drops them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            if (i_wrJmp && w_full) begin
                r_ovf_err <= 1'b1;
            end
            if (i_rdJmp && w_empty) begin
                r_udf_err <= 1'b1;
            end
        end
    end

    // Line selection is captured alongside the RAM read so a same-cycle rdJmp
    // only affects the following read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_top <= '0;
        end else if (i_rdEn) begin
            r_sel_top <= r_rd_ptr;
        end
    end

    assign w_sel_bot = r_sel_top + PTR_WIDTH'(1);

    for (genvar gi = 0; gi < LINE_NUM; gi++) begin : g_line
        line_ram #(
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH)
        ) u_line_ram (
            .clk      (clk),
            .rst      (rst),
            .i_wrEn   (i_wrEn && (r_wr_ptr == PTR_WIDTH'(gi))),
            .i_wrAddr (i_wrAddr),
            .i_wrData (i_wrData),
            .i_rdEn   (i_rdEn),
            .i_rdAddr (i_rdAddr),
            .o_rdData (w_line_data[gi])
        );
    end

    assign o_fifoNum = r_fifo_num;
    assign o_rdReady = r_rd_ready;
    assign o_dataTop = w_line_data[r_sel_top];
    assign o_dataBot = w_line_data[w_sel_bot];
    assign o_dataVld = r_data_vld;
    assign o_ovfErr  = r_ovf_err;
    assign o_udfErr  = r_udf_err;

endmodule
